// File: rtl/extract_feed_arbiter.sv
// extract_feed_arbiter
//   Shares one message extractor among NUM_FEEDS Avalon-ST feeds. Grants are
//   packet-granular round-robin: once a feed wins, it owns the extractor from
//   SOP through the EOP handshake. An optional guard gap of GAP_CYCLES idle
//   cycles follows each packet so the extractor can drain its final message.
//   While idle, beats that are not SOP are accepted and dropped.
//
// Ports
//   clk, reset_n           clock, synchronous active-low reset
//   feed_valid/sop/eop     per-feed Avalon-ST sideband, NUM_FEEDS bits
//   feed_data/feed_empty   feed i at [i*DATA_W +: DATA_W] / [i*EMPTY_W +: EMPTY_W]
//   feed_ready             per-feed ready
//   ext_valid/sop/eop/data/empty, ext_ready   extractor in_* port
//   ext_feed_id            currently granted feed
//   busy                   high while in PASS or GAP
//   stray_drop             pulse: a non-SOP beat was discarded while idle
//
// Build option
//   EXTRACT_ARB_STATS_EN   adds stat_sel / stat_pkts / stat_strays and the
//                          per-feed packet and stray counters behind them.
module extract_feed_arbiter #(
   parameter int NUM_FEEDS  = 4,
   parameter int DATA_W     = 64,
   parameter int EMPTY_W    = 3,
   parameter int GAP_CYCLES = 1,
   parameter int ID_W       = 2
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_FEEDS-1:0]           feed_valid,
   input  logic [NUM_FEEDS-1:0]           feed_sop,
   input  logic [NUM_FEEDS-1:0]           feed_eop,
   input  logic [NUM_FEEDS*DATA_W-1:0]    feed_data,
   input  logic [NUM_FEEDS*EMPTY_W-1:0]   feed_empty,
   output logic [NUM_FEEDS-1:0]           feed_ready,
   output logic                           ext_valid,
   output logic                           ext_sop,
   output logic                           ext_eop,
   output logic [DATA_W-1:0]              ext_data,
   output logic [EMPTY_W-1:0]             ext_empty,
   input  logic                           ext_ready,
   output logic [ID_W-1:0]                ext_feed_id,
   output logic                           busy,
   output logic                           stray_drop
`ifdef EXTRACT_ARB_STATS_EN
   ,
   input  logic [ID_W-1:0]                stat_sel,
   output logic [31:0]                    stat_pkts,
   output logic [31:0]                    stat_strays
`endif
);

   typedef enum logic [1:0] {IDLE, PASS, GAP} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [ID_W-1:0]    last_grant_q, last_grant_d;
   logic [3:0]         gap_cnt_q, gap_cnt_d;

   logic [NUM_FEEDS-1:0] cand;
   logic [NUM_FEEDS-1:0] stray;
   logic                 win_found;
   logic [ID_W-1:0]      win_id;
   int                   idx;

   logic                 sel_valid, sel_sop, sel_eop;
   logic [DATA_W-1:0]    sel_data;
   logic [EMPTY_W-1:0]   sel_empty;
   logic                 eop_hs;

   assign cand  = feed_valid & feed_sop;
   assign stray = feed_valid & ~feed_sop;

   // Round-robin search starting one past the previous winner.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int i = 1; i <= NUM_FEEDS; i++) begin
         idx = (int'(last_grant_q) + i) % NUM_FEEDS;
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
         end
      end
   end

   // Zero-latency mux from the granted feed.
   always_comb begin
      sel_valid = feed_valid[int'(grant_q)];
      sel_sop   = feed_sop[int'(grant_q)];
      sel_eop   = feed_eop[int'(grant_q)];
      sel_data  = feed_data[int'(grant_q)*DATA_W +: DATA_W];
      sel_empty = feed_empty[int'(grant_q)*EMPTY_W +: EMPTY_W];
   end

   assign eop_hs = (state_q == PASS) && sel_valid && ext_ready && sel_eop;

   // Outputs are forced low while reset_n is asserted, even before the
   // first clock edge has brought the state back to IDLE.
   always_comb begin
      ext_valid  = 1'b0;
      ext_sop    = 1'b0;
      ext_eop    = 1'b0;
      ext_data   = '0;
      ext_empty  = '0;
      feed_ready = '0;
      stray_drop = 1'b0;
      if (reset_n) begin
         case (state_q)
            PASS: begin
               ext_valid                 = sel_valid;
               ext_sop                   = sel_sop;
               ext_eop                   = sel_eop;
               ext_data                  = sel_data;
               ext_empty                 = sel_empty;
               feed_ready[int'(grant_q)] = ext_ready;
            end
            IDLE: begin
               // Non-SOP beats can never start a packet; swallow them.
               feed_ready = stray;
               stray_drop = |stray;
            end
            default: ;
         endcase
      end
   end

   assign ext_feed_id = reset_n ? grant_q : '0;
   assign busy        = reset_n && (state_q != IDLE);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      gap_cnt_d    = gap_cnt_q;
      case (state_q)
         IDLE: if (win_found) begin
            state_d      = PASS;
            grant_d      = win_id;
            last_grant_d = win_id;
         end
         PASS: if (eop_hs) begin
            if (GAP_CYCLES > 0) begin
               state_d   = GAP;
               gap_cnt_d = 4'(GAP_CYCLES - 1);
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) state_d = IDLE;
            else                 gap_cnt_d = gap_cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
      // Last grant parks at the top feed so feed 0 wins first after reset.
      if (!reset_n) begin
         state_d      = IDLE;
         grant_d      = '0;
         last_grant_d = ID_W'(NUM_FEEDS - 1);
         gap_cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q    <= gap_cnt_d;
   end

`ifdef EXTRACT_ARB_STATS_EN
   logic [NUM_FEEDS-1:0][31:0] pkts_q, pkts_d;
   logic [NUM_FEEDS-1:0][31:0] strays_q, strays_d;

   always_comb begin
      pkts_d   = pkts_q;
      strays_d = strays_q;
      if (state_q == IDLE) begin
         for (int i = 0; i < NUM_FEEDS; i++)
            if (stray[i]) strays_d[i] = strays_q[i] + 32'd1;
      end
      if (eop_hs) pkts_d[int'(grant_q)] = pkts_q[int'(grant_q)] + 32'd1;
      if (!reset_n) begin
         pkts_d   = '0;
         strays_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      pkts_q   <= pkts_d;
      strays_q <= strays_d;
   end

   always_comb begin
      stat_pkts   = '0;
      stat_strays = '0;
      if (reset_n && int'(stat_sel) < NUM_FEEDS) begin
         stat_pkts   = pkts_q[int'(stat_sel)];
         stat_strays = strays_q[int'(stat_sel)];
      end
   end
`endif

endmodule

// File: tb/tb_extract_feed_arbiter.sv
// Bench for extract_feed_arbiter: per-feed source queues drive Avalon-ST
// beats; a packet-level model (round-robin pick, per-feed expected-beat
// scoreboard, idle/pass/gap phase tracking) predicts every output each cycle.
module tb_extract_feed_arbiter;
   localparam int NF = 4, DW = 64, EW = 3, GAP = 1, IW = 2;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NF-1:0]    feed_valid, feed_sop, feed_eop, feed_ready;
   logic [NF*DW-1:0] feed_data;
   logic [NF*EW-1:0] feed_empty;
   logic             ext_valid, ext_sop, ext_eop, ext_ready, busy, stray_drop;
   logic [DW-1:0]    ext_data;
   logic [EW-1:0]    ext_empty;
   logic [IW-1:0]    ext_feed_id;
`ifdef EXTRACT_ARB_STATS_EN
   logic [IW-1:0]    stat_sel;
   logic [31:0]      stat_pkts, stat_strays;
`endif

   always #5 clk = ~clk;

   extract_feed_arbiter #(.NUM_FEEDS(NF), .DATA_W(DW), .EMPTY_W(EW),
                          .GAP_CYCLES(GAP), .ID_W(IW)) dut (
      .clk(clk), .reset_n(reset_n),
      .feed_valid(feed_valid), .feed_sop(feed_sop), .feed_eop(feed_eop),
      .feed_data(feed_data), .feed_empty(feed_empty), .feed_ready(feed_ready),
      .ext_valid(ext_valid), .ext_sop(ext_sop), .ext_eop(ext_eop),
      .ext_data(ext_data), .ext_empty(ext_empty), .ext_ready(ext_ready),
      .ext_feed_id(ext_feed_id), .busy(busy), .stray_drop(stray_drop)
`ifdef EXTRACT_ARB_STATS_EN
      , .stat_sel(stat_sel), .stat_pkts(stat_pkts), .stat_strays(stat_strays)
`endif
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
      logic [EW-1:0] empty;
   } beat_t;

   beat_t src_q[NF][$];
   beat_t exp_q[NF][$];
   int    sop_ids[$];
   int    m_owner, m_last, gap_left;
   int    pkts[NF], strays[NF];
   int    busy_cyc, hs_cnt, drop_cnt;
   bit    bubbles, rnd_ready;
   int    checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NF-1:0] c, input int last);
      for (int k = 1; k <= NF; k++)
         if (c[(last + k) % NF]) return (last + k) % NF;
      return -1;
   endfunction

   task automatic model_init();
      m_owner = -1; m_last = NF - 1; gap_left = 0;
      for (int i = 0; i < NF; i++) begin pkts[i] = 0; strays[i] = 0; end
   endtask

   task automatic add_pkt(input int f, input int len, input bit strayb, input int emp);
      beat_t b;
      if (strayb) begin
         b.data = {$urandom, $urandom}; b.sop = 1'b0; b.eop = 1'($urandom);
         b.empty = EW'($urandom);
         src_q[f].push_back(b);
      end
      for (int k = 0; k < len; k++) begin
         b.data  = {$urandom, $urandom};
         b.sop   = (k == 0);
         b.eop   = (k == len - 1);
         b.empty = (emp >= 0) ? EW'(emp) : EW'($urandom);
         src_q[f].push_back(b);
         exp_q[f].push_back(b);
      end
   endtask

   task automatic drive(input logic [NF-1:0] acc);
      beat_t b;
      for (int i = 0; i < NF; i++) begin
         if (acc[i] && src_q[i].size() > 0) b = src_q[i].pop_front();
         if (src_q[i].size() > 0 && (!bubbles || $urandom_range(3) != 0)) begin
            b = src_q[i][0];
            feed_valid[i] = 1'b1;
            feed_sop[i]   = b.sop;
            feed_eop[i]   = b.eop;
            feed_data[i*DW +: DW] = b.data;
            feed_empty[i*EW +: EW] = b.empty;
         end else begin
            feed_valid[i] = 1'b0;
            feed_sop[i]   = 1'($urandom);
            feed_eop[i]   = 1'($urandom);
            feed_data[i*DW +: DW] = {$urandom, $urandom};
            feed_empty[i*EW +: EW] = EW'($urandom);
         end
      end
      ext_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
   endtask

   task automatic rst_checks();
      chk("rst_out", {feed_ready, ext_valid, ext_sop, ext_eop, ext_data, ext_empty,
                      ext_feed_id, busy, stray_drop}, 0);
`ifdef EXTRACT_ARB_STATS_EN
      chk("rst_stats", {stat_pkts, stat_strays}, 0);
`endif
   endtask

   task automatic monitor();
      logic [NF-1:0] cand, strv, er;
      beat_t         b;
      int            w;
      cand = feed_valid & feed_sop;
      strv = feed_valid & ~feed_sop;
      if (busy) busy_cyc++;
      if (stray_drop) drop_cnt++;
      if (m_owner < 0 && gap_left == 0) begin
         chk("idle_busy", busy, 0);
         chk("idle_ext", {ext_valid, ext_sop, ext_eop, ext_data, ext_empty}, 0);
         chk("idle_ready", feed_ready, strv);
         chk("idle_drop", stray_drop, |strv);
         for (int i = 0; i < NF; i++) if (strv[i]) strays[i]++;
         w = rr_pick(cand, m_last);
         if (w >= 0) begin m_owner = w; m_last = w; end
      end else if (m_owner >= 0) begin
         er = '0;
         er[m_owner] = ext_ready;
         chk("pass_busy", busy, 1);
         chk("pass_id", ext_feed_id, m_owner);
         chk("pass_ready", feed_ready, er);
         chk("pass_valid", ext_valid, feed_valid[m_owner]);
         if (feed_valid[m_owner] && ext_ready) begin
            hs_cnt++;
            if (exp_q[m_owner].size() == 0) chk("sb_underflow", 1, 0);
            else begin
               b = exp_q[m_owner].pop_front();
               chk("beat", {ext_sop, ext_eop, ext_empty, ext_data}, {b.sop, b.eop, b.empty, b.data});
               if (b.sop) sop_ids.push_back(int'(ext_feed_id));
               if (b.eop) begin pkts[m_owner]++; m_owner = -1; gap_left = GAP; end
            end
         end
      end else begin
         chk("gap_busy", busy, 1);
         chk("gap_out", {ext_valid, ext_data, feed_ready, stray_drop}, 0);
         gap_left--;
      end
   endtask

   task automatic step();
      logic [NF-1:0] acc;
      @(negedge clk);
      if (reset_n) monitor(); else rst_checks();
      acc = feed_valid & feed_ready;
      @(posedge clk); #1;
      drive(acc);
   endtask

   task automatic start(input bit bub, input bit rr);
      bubbles = bub; rnd_ready = rr;
      busy_cyc = 0; hs_cnt = 0; drop_cnt = 0;
      sop_ids.delete();
      drive('0);
   endtask

   task automatic run_until_idle(input int budget);
      int  n = 0;
      bit  pend = 1'b1;
      while (pend && n < budget) begin
         step();
         n++;
         pend = (m_owner >= 0) || (gap_left > 0);
         for (int i = 0; i < NF; i++) if (src_q[i].size() > 0) pend = 1'b1;
      end
      if (pend) chk("timeout", 1, 0);
      step(); step();
   endtask

   task automatic do_reset(input int cyc);
      for (int i = 0; i < NF; i++) begin src_q[i].delete(); exp_q[i].delete(); end
      reset_n = 1'b0;
      for (int k = 0; k < cyc; k++) step();
      reset_n = 1'b1;
      model_init();
   endtask

`ifdef EXTRACT_ARB_STATS_EN
   task automatic chk_stats();
      for (int i = 0; i < NF; i++) begin
         stat_sel = IW'(i);
         #1;
         chk("stat_pkts", stat_pkts, pkts[i]);
         chk("stat_strays", stat_strays, strays[i]);
      end
   endtask
`endif

   initial begin
      reset_n = 1'b0; ext_ready = 1'b0;
      feed_valid = '0; feed_sop = '0; feed_eop = '0; feed_data = '0; feed_empty = '0;
`ifdef EXTRACT_ARB_STATS_EN
      stat_sel = '0;
`endif
      model_init();
      // Active inputs during reset: a pending SOP on feed 0 and a stray on feed 1.
      add_pkt(0, 2, 1'b0, -1);
      add_pkt(1, 0, 1'b1, -1);
      start(1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step();
      reset_n = 1'b1;
      run_until_idle(200);

      // 3-beat packet on feed 0.
      do_reset(2);
      add_pkt(0, 3, 1'b0, -1);
      start(1'b0, 1'b0);
      run_until_idle(200);
      chk("t1_beats", hs_cnt, 3);
      chk("t1_busy", busy_cyc, 3 + GAP);

      // All feeds present SOP together: grants 0,1,2,3.
      do_reset(2);
      for (int f = 0; f < NF; f++) add_pkt(f, 2 + f, 1'b0, -1);
      start(1'b0, 1'b0);
      run_until_idle(500);
      for (int k = 0; k < NF; k++)
         chk("t2_order", (k < sop_ids.size()) ? sop_ids[k] : -1, k);

      // Single-beat packet with empty=5.
      do_reset(2);
      add_pkt(2, 1, 1'b0, 5);
      start(1'b0, 1'b0);
      run_until_idle(200);
      chk("t3_beats", hs_cnt, 1);
      chk("t3_busy", busy_cyc, 1 + GAP);

      // Stray on feed 1 while idle.
      do_reset(2);
      add_pkt(1, 0, 1'b1, -1);
      start(1'b0, 1'b0);
      run_until_idle(200);
      chk("t4_drop", drop_cnt, 1);
      chk("t4_beats", hs_cnt, 0);

      // Reset in mid-packet on feed 3, then feed 0 and feed 3 both pending.
      do_reset(2);
      add_pkt(3, 8, 1'b0, -1);
      start(1'b0, 1'b0);
      for (int k = 0; k < 4; k++) step();
      chk("t5_mid", hs_cnt, 3);
      do_reset(2);
      add_pkt(3, 2, 1'b0, -1);
      add_pkt(0, 2, 1'b0, -1);
      start(1'b0, 1'b0);
      run_until_idle(200);
      chk("t5_first", (sop_ids.size() > 0) ? sop_ids[0] : -1, 0);
      chk("t5_second", (sop_ids.size() > 1) ? sop_ids[1] : -1, 3);

`ifdef EXTRACT_ARB_STATS_EN
      do_reset(2);
      for (int k = 0; k < 5; k++) add_pkt(1, 1 + k, 1'b0, -1);
      start(1'b0, 1'b0);
      run_until_idle(500);
      stat_sel = IW'(1);
      #1;
      chk("t6_pkts", stat_pkts, 5);
      chk("t6_strays", stat_strays, 0);
`endif

      // Randomized traffic: bubbles, backpressure, occasional strays.
      do_reset(2);
      for (int n = 0; n < 200; n++)
         add_pkt($urandom_range(NF - 1), $urandom_range(5, 1), $urandom_range(4) == 0, -1);
      start(1'b1, 1'b1);
      run_until_idle(20000);
      for (int i = 0; i < NF; i++) chk("rnd_drained", exp_q[i].size(), 0);
`ifdef EXTRACT_ARB_STATS_EN
      chk_stats();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
